// File: rtl/stage_renderer.sv
// Frame renderer: raster-scans the tile playfield through a 1-cycle query pipeline, then overlays enabled bombs.
// Optional macro EXPLOSION_FLASH_EN alternates the explosion colour between even and odd frames.
module stage_renderer #(
  parameter int ORIGIN_X  = 72,
  parameter int ORIGIN_Y  = 32,
  parameter int TILES     = 11,
  parameter int TILE_PX   = 16,
  parameter int NUM_BOMBS = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [8:0]  qx,
  output logic [7:0]  qy,
  input  logic [3:0]  map_tile_id,
  input  logic        has_explosion,
  output logic [2:0]  bomb_id,
  input  logic [17:0] bomb_info,
  output logic [8:0]  vga_x,
  output logic [7:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic        busy,
  output logic        done
);

  localparam int SPAN = TILES * TILE_PX;
  localparam int PW   = $clog2(SPAN);
  localparam int OW   = $clog2(TILE_PX);
  localparam logic [8:0]    OX     = 9'(ORIGIN_X);
  localparam logic [7:0]    OY     = 8'(ORIGIN_Y);
  localparam logic [PW-1:0] P_LAST = PW'(SPAN - 1);
  localparam logic [OW-1:0] O_LAST = OW'(TILE_PX - 1);
  localparam logic [2:0]    B_LAST = 3'(NUM_BOMBS - 1);

  typedef enum logic [2:0] {
    IDLE, TILE_SCAN, TILE_FLUSH, BOMB_SEL, BOMB_CHK, BOMB_DRAW, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] px_q, px_d, py_q, py_d;
  logic [OW-1:0] ox_q, ox_d, oy_q, oy_d;
  logic [8:0]    qx_q, qx_d, bx_q, bx_d, vga_x_q, vga_x_d;
  logic [7:0]    qy_q, qy_d, by_q, by_d, vga_y_q, vga_y_d;
  logic [2:0]    bomb_id_q, bomb_id_d, colour_q, colour_d;
  logic          plot_q, plot_d, busy_q, busy_d, done_q, done_d;
  logic [2:0]    expl_colour, pix_colour;
  logic          corner, next_bomb;

`ifdef EXPLOSION_FLASH_EN
  logic frame_par_q, frame_par_d;
  always_comb frame_par_d = frame_par_q ^ (state_q == DONE);
  assign expl_colour = frame_par_q ? 3'b110 : 3'b100;
`else
  assign expl_colour = 3'b100;
`endif

  always_comb begin
    if (has_explosion) begin
      pix_colour = expl_colour;
    end else begin
      case (map_tile_id)
        4'd0:    pix_colour = 3'b010;
        4'd1:    pix_colour = 3'b111;
        4'd2:    pix_colour = 3'b011;
        default: pix_colour = 3'b101;
      endcase
    end
  end

  // Bomb sprites are rounded: the four corner pixels are left untouched.
  assign corner = (ox_q == '0 || ox_q == O_LAST) && (oy_q == '0 || oy_q == O_LAST);

  always_comb begin
    state_d   = state_q;
    px_d      = px_q;
    py_d      = py_q;
    ox_d      = ox_q;
    oy_d      = oy_q;
    qx_d      = qx_q;
    qy_d      = qy_q;
    bx_d      = bx_q;
    by_d      = by_q;
    bomb_id_d = bomb_id_q;
    vga_x_d   = vga_x_q;
    vga_y_d   = vga_y_q;
    colour_d  = colour_q;
    plot_d    = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    next_bomb = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = TILE_SCAN;
          busy_d  = 1'b1;
          px_d    = '0;
          py_d    = '0;
          qx_d    = OX;
          qy_d    = OY;
        end
      end
      TILE_SCAN: begin
        // Plot the pixel queried last cycle while issuing the next query.
        plot_d   = 1'b1;
        vga_x_d  = qx_q;
        vga_y_d  = qy_q;
        colour_d = pix_colour;
        if (px_q == P_LAST) begin
          px_d = '0;
          py_d = py_q + PW'(1);
        end else begin
          px_d = px_q + PW'(1);
        end
        qx_d = OX + 9'(px_d);
        qy_d = OY + 8'(py_d);
        if (px_d == P_LAST && py_d == P_LAST) state_d = TILE_FLUSH;
      end
      TILE_FLUSH: begin
        plot_d    = 1'b1;
        vga_x_d   = qx_q;
        vga_y_d   = qy_q;
        colour_d  = pix_colour;
        qx_d      = OX;
        qy_d      = OY;
        bomb_id_d = '0;
        state_d   = BOMB_SEL;
      end
      BOMB_SEL: state_d = BOMB_CHK;
      BOMB_CHK: begin
        if (bomb_info[0]) begin
          bx_d    = bomb_info[9:1];
          by_d    = bomb_info[17:10];
          ox_d    = '0;
          oy_d    = '0;
          state_d = BOMB_DRAW;
        end else begin
          next_bomb = 1'b1;
        end
      end
      BOMB_DRAW: begin
        plot_d   = ~corner;
        vga_x_d  = bx_q + 9'(ox_q);
        vga_y_d  = by_q + 8'(oy_q);
        colour_d = 3'b000;
        if (ox_q == O_LAST) begin
          ox_d = '0;
          if (oy_q == O_LAST) next_bomb = 1'b1;
          else                oy_d = oy_q + OW'(1);
        end else begin
          ox_d = ox_q + OW'(1);
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (next_bomb) begin
      if (bomb_id_q == B_LAST) begin
        bomb_id_d = '0;
        state_d   = DONE;
      end else begin
        bomb_id_d = bomb_id_q + 3'd1;
        state_d   = BOMB_SEL;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      px_q      <= '0;
      py_q      <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      qx_q      <= OX;
      qy_q      <= OY;
      bx_q      <= '0;
      by_q      <= '0;
      bomb_id_q <= '0;
      vga_x_q   <= '0;
      vga_y_q   <= '0;
      colour_q  <= '0;
      plot_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef EXPLOSION_FLASH_EN
      frame_par_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      px_q      <= px_d;
      py_q      <= py_d;
      ox_q      <= ox_d;
      oy_q      <= oy_d;
      qx_q      <= qx_d;
      qy_q      <= qy_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
      bomb_id_q <= bomb_id_d;
      vga_x_q   <= vga_x_d;
      vga_y_q   <= vga_y_d;
      colour_q  <= colour_d;
      plot_q    <= plot_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef EXPLOSION_FLASH_EN
      frame_par_q <= frame_par_d;
`endif
    end
  end

  assign qx         = qx_q;
  assign qy         = qy_q;
  assign bomb_id    = bomb_id_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = colour_q;
  assign vga_plot   = plot_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_stage_renderer.sv
// Self-checking bench for stage_renderer: palette vector table, abort-on-reset, and full frames against a plot scoreboard.
module tb_stage_renderer;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [8:0]  qx;
  logic [7:0]  qy;
  logic [3:0]  map_tile_id;
  logic        has_explosion;
  logic [2:0]  bomb_id;
  logic [17:0] bomb_info;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot, busy, done;

  stage_renderer dut (
    .clk(clk), .reset(reset), .start(start),
    .qx(qx), .qy(qy), .map_tile_id(map_tile_id), .has_explosion(has_explosion),
    .bomb_id(bomb_id), .bomb_info(bomb_info),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .done(done)
  );

  always #10 clk = ~clk;

  // Game-state model configuration
  bit          cfg_layout;
  logic [3:0]  cfg_tile;
  bit          cfg_expl;
  bit          ex_on;
  int          ex_x, ex_y;
  bit          b_en [8];
  logic [8:0]  b_x  [8];
  logic [7:0]  b_y  [8];
  bit          par;

  function automatic logic [3:0] tile_at(input int x, input int y, input bit lay, input logic [3:0] ct);
    if (!lay) return ct;
    return (x >= 88 && x < 104 && y >= 32 && y < 48) ? 4'd1 : 4'd0;
  endfunction

  function automatic bit expl_at(input int x, input int y, input bit lay, input bit ce,
                                 input bit on, input int ex, input int ey);
    if (!lay) return ce;
    return on && x == ex && y == ey;
  endfunction

  assign map_tile_id   = tile_at(int'(qx), int'(qy), cfg_layout, cfg_tile);
  assign has_explosion = expl_at(int'(qx), int'(qy), cfg_layout, cfg_expl, ex_on, ex_x, ex_y);
  assign bomb_info     = {b_y[bomb_id], b_x[bomb_id], b_en[bomb_id]};

  function automatic logic [2:0] expl_col();
`ifdef EXPLOSION_FLASH_EN
    return par ? 3'b110 : 3'b100;
`else
    return 3'b100;
`endif
  endfunction

  function automatic logic [2:0] exp_col(input int x, input int y);
    logic [3:0] t;
    t = tile_at(x, y, cfg_layout, cfg_tile);
    if (expl_at(x, y, cfg_layout, cfg_expl, ex_on, ex_x, ex_y)) return expl_col();
    case (t)
      4'd0:    return 3'b010;
      4'd1:    return 3'b111;
      4'd2:    return 3'b011;
      default: return 3'b101;
    endcase
  endfunction

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  // Plot scoreboard: entries are {x, y, colour}
  logic [19:0] exp_q[$];
  bit          mon_on = 0;
  int          plot_cnt = 0, raw_plots = 0;
  logic [19:0] first_p, last_p;

  always @(negedge clk) begin
    if (vga_plot) begin
      raw_plots++;
      if (mon_on) begin
        if (plot_cnt == 0) first_p = {vga_x, vga_y, vga_colour};
        last_p = {vga_x, vga_y, vga_colour};
        plot_cnt++;
        chk("plot_while_busy", busy, 1);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL extra_plot: got %0h expected none", {vga_x, vga_y, vga_colour});
        end else begin
          chk("plot", {vga_x, vga_y, vga_colour}, exp_q.pop_front());
        end
      end
    end
  end

  task automatic push_scan();
    for (int y = 0; y < 176; y++)
      for (int x = 0; x < 176; x++)
        exp_q.push_back({9'(72 + x), 8'(32 + y), exp_col(72 + x, 32 + y)});
  endtask

  task automatic push_bomb(input int bx, input int by);
    for (int oy = 0; oy < 16; oy++)
      for (int ox = 0; ox < 16; ox++)
        if (!((ox == 0 || ox == 15) && (oy == 0 || oy == 15)))
          exp_q.push_back({9'(bx + ox), 8'(by + oy), 3'b000});
  endtask

  task automatic wait_plot(input string nm);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (vga_plot) got = 1;
    end
    chk(nm, got, 1);
  endtask

  task automatic run_frame(input int exp_cycles, input int exp_plots, input bit mid_start, input bit drop_bomb);
    int n = 0;
    bit seen = 0;
    bit busy_prev = 0;
    plot_cnt = 0;
    mon_on   = 1;
    start    = 1;
    while (!seen && n < 40000) begin
      busy_prev = busy;
      step();
      n++;
      start = mid_start && n == 5000;
      if (n == 1) chk("busy_after_start", busy, 1);
      if (drop_bomb && plot_cnt >= 30976 + 100) b_en[2] = 0;
      if (done) seen = 1;
    end
    chk("done_seen", seen, 1);
    chk("done_cycle", n, exp_cycles);
    chk("busy_before_done", busy_prev, 1);
    chk("busy_at_done", busy, 0);
    step();
    chk("done_one_cycle", done, 0);
    repeat (4) step();
    chk("plot_count", plot_cnt, exp_plots);
    chk("queue_drained", exp_q.size(), 0);
    mon_on = 0;
    par ^= 1'b1;
  endtask

  typedef struct {
    logic [3:0] tile;
    bit         expl;
    logic [2:0] col;
  } pal_vec_t;

  pal_vec_t pal[9];

  initial begin
    int snap;
    bit hit;
    pal[0] = '{4'd0,  1'b0, 3'b010};
    pal[1] = '{4'd1,  1'b0, 3'b111};
    pal[2] = '{4'd2,  1'b0, 3'b011};
    pal[3] = '{4'd3,  1'b0, 3'b101};
    pal[4] = '{4'd9,  1'b0, 3'b101};
    pal[5] = '{4'd15, 1'b0, 3'b101};
    pal[6] = '{4'd0,  1'b1, 3'b100};
    pal[7] = '{4'd1,  1'b1, 3'b100};
    pal[8] = '{4'd7,  1'b1, 3'b100};

    reset = 1; start = 0; par = 0;
    cfg_layout = 0; cfg_tile = 0; cfg_expl = 0; ex_on = 0; ex_x = 0; ex_y = 0;
    for (int i = 0; i < 8; i++) begin b_en[i] = 0; b_x[i] = '0; b_y[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_qx", qx, 72);
    chk("rst_qy", qy, 32);
    chk("rst_bomb_id", bomb_id, 0);
    chk("rst_vga_x", vga_x, 0);
    chk("rst_vga_y", vga_y, 0);
    chk("rst_colour", vga_colour, 0);
    chk("rst_plot", vga_plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 0;

    // Palette vectors: first plot of a short frame, aborted by reset
    for (int v = 0; v < 9; v++) begin
      cfg_tile = pal[v].tile;
      cfg_expl = pal[v].expl;
      step();
      start = 1;
      step();
      start = 0;
      wait_plot("pal_plot_seen");
      chk("pal_colour", vga_colour, pal[v].col);
      chk("pal_xy", {vga_x, vga_y}, {9'd72, 8'd32});
      reset = 1;
      #1;
      chk("pal_abort_plot", vga_plot, 0);
      @(posedge clk);
      #1 reset = 0;
    end
    cfg_tile = 0; cfg_expl = 0;

    // Abort at plot 1000
    step();
    start = 1;
    step();
    start = 0;
    snap = raw_plots;
    hit = 0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      step();
      if (raw_plots - snap >= 1000) hit = 1;
    end
    chk("abort_reached_1000", hit, 1);
    reset = 1;
    #1;
    chk("abort_plot", vga_plot, 0);
    chk("abort_busy", busy, 0);
    snap = raw_plots;
    repeat (3) step();
    chk("abort_no_plots", raw_plots - snap, 0);
    @(posedge clk);
    #1 reset = 0;
    par = 0;
    step();

    // Frame 1: all floor, no bombs, stray start mid-frame
    push_scan();
    run_frame(30990, 30976, 1, 0);
    chk("first_plot", first_p, {9'd72, 8'd32, 3'b010});
    chk("last_plot", last_p, {9'd247, 8'd207, 3'b010});
    chk("idle_bomb_id", bomb_id, 0);

    // Frame 2: wall tile, explosion at (90,40), bomb slot 2 vanishing mid-draw
    cfg_layout = 1; ex_on = 1; ex_x = 90; ex_y = 40;
    b_en[2] = 1; b_x[2] = 9'd104; b_y[2] = 8'd48;
    push_scan();
    push_bomb(104, 48);
    run_frame(31246, 30976 + 252, 0, 1);
    chk("f2_first_plot", first_p, {9'd72, 8'd32, 3'b010});

    // Frame 3: explosion at the first pixel, colour follows frame parity
    ex_x = 72; ex_y = 32;
    step();
    start = 1;
    step();
    start = 0;
    wait_plot("f3_plot_seen");
    chk("f3_expl_colour", vga_colour, expl_col());
    chk("f3_xy", {vga_x, vga_y}, {9'd72, 8'd32});
    reset = 1;
    #1;
    chk("f3_abort_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_renderer.md
Name: stage_renderer

Overview:
- Frame renderer that reads the bomb/stage state block and writes pixels to the DE1 VGA adapter.
- On a start pulse it scans the 11x11 tile playfield pixel by pixel. It drives query coordinates, samples `map_tile_id` and `has_explosion`, and plots a palette colour for each pixel.
- It then overlays the active bombs by stepping `bomb_id` 0..5 and drawing each enabled bomb reported on `bomb_info`.
- It sits between the game-state block and the VGA adapter, driven by the top-level frame sequencer.

Parameters:
- ORIGIN_X, 72, pixel X of the playfield's top-left corner
- ORIGIN_Y, 32, pixel Y of the playfield's top-left corner
- TILES, 11, tiles per row and per column
- TILE_PX, 16, pixels per tile edge (power of two)
- NUM_BOMBS, 6, number of bomb slots polled

Ports:
- clk  in  1  50 MHz system clock
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle pulse; begins a frame when idle
- qx  out  9  query pixel X, driven to the state block's X
- qy  out  8  query pixel Y, driven to the state block's Y
- map_tile_id  in  4  tile id at (qx,qy)
- has_explosion  in  1  explosion present at (qx,qy)
- bomb_id  out  3  bomb slot being polled
- bomb_info  in  18  {bY[7:0], bX[8:0], enabled}
- vga_x  out  9  plot X
- vga_y  out  8  plot Y
- vga_colour  out  3  plot colour {R,G,B}
- vga_plot  out  1  write strobe to the VGA adapter
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse when the frame is finished

Behaviour:
- Reset values: `qx`=ORIGIN_X, `qy`=ORIGIN_Y, `bomb_id`=0, `vga_x`=0, `vga_y`=0, `vga_colour`=0, `vga_plot`=0, `busy`=0, `done`=0, state=IDLE.
- A reset asserted mid-frame aborts immediately; no further plots occur.
- The state block's outputs are combinational from `qx`/`qy`/`bomb_id`. The renderer registers its query and samples the response one cycle later, giving a fixed 1-cycle pipeline.
- IDLE:
  - `start`=1 -> TILE_SCAN; `busy`<=1; pixel counters px=0, py=0.
  - `start` outside IDLE is ignored.
- TILE_SCAN:
  - Cycle n: `qx`=ORIGIN_X+px, `qy`=ORIGIN_Y+py.
  - Cycle n+1: `vga_plot`=1, `vga_x`/`vga_y` = the cycle-n coordinates, colour from the sampled inputs.
  - px increments 0..TILES*TILE_PX-1 (0..175), then wraps to 0 and py increments. The scan is raster order, one pixel per cycle with no bubbles.
  - After the last query (175,175) -> TILE_FLUSH: one cycle, plots the final pixel -> BOMB_SEL with `bomb_id`=0.
  - Plot count is exactly 176*176 = 30976.
- Palette (`has_explosion` overrides tile):
  - explosion 3'b100
  - tile 0 floor 3'b010
  - tile 1 wall 3'b111
  - tile 2 brick 3'b011
  - tile >=3 power-up 3'b101
- BOMB_SEL:
  - Drive `bomb_id`; wait one cycle; sample `bomb_info`.
  - enabled=1 -> BOMB_DRAW with latched bX, bY.
  - enabled=0 -> next id.
- BOMB_DRAW:
  - Iterate ox, oy 0..TILE_PX-1 in raster order, one per cycle.
  - `vga_plot`=1 with `vga_x`=bX+ox, `vga_y`=bY+oy, colour 3'b000.
  - Corner pixels, where ox is in {0,15} AND oy is in {0,15}, are skipped with `vga_plot`=0 that cycle. That gives 252 plots per bomb over 256 cycles.
  - Then advance to the next id.
- After `bomb_id`=NUM_BOMBS-1 is handled -> DONE: `done`=1 for one cycle, `busy`<=0 -> IDLE; `bomb_id` returns to 0.
- `vga_plot` is never asserted in IDLE or DONE.
- Arithmetic is 9-bit (X) and 8-bit (Y) unsigned; playfield coordinates never wrap with default parameters.
- `bomb_info` is not re-read during BOMB_DRAW. If the bomb disappears mid-draw, the draw still completes.

Optional Feature:
- Macro: `EXPLOSION_FLASH_EN`.
- Defined: a 1-bit frame parity register toggles on each `done` (reset 0). Explosion colour is 3'b100 on even frames and 3'b110 on odd frames.
- Undefined: no parity register; explosion colour is always 3'b100.

Test Plan:
- All-floor stage model, no bombs, one start pulse -> exactly 30976 plots, all colour 3'b010. First plot at (72,32), last at (247,207). `done` pulses 30978 + 12 cycles after start (30976 scan + flush + 6 two-cycle bomb polls), `busy` falls with it.
- Tile 1 at row 0 col 1, `has_explosion`=1 at pixel (90,40) -> pixels x 88..103, y 32..47 are 3'b111 except (90,40)=3'b100. Pixel (72,32)=3'b010.
- Bomb slot 2 enabled at bX=104, bY=48, others disabled -> 252 black plots covering x 104..119, y 48..63. Corners (104,48), (119,48), (104,63), (119,63) are not plotted.
- Start pulsed again mid-frame -> ignored; plot count and `done` timing unchanged. Reset asserted at plot 1000 -> `vga_plot`=0 and `busy`=0 immediately; the next start begins at (72,32).
- `EXPLOSION_FLASH_EN` defined, explosion at (72,32), two consecutive frames -> colour 3'b100 then 3'b110. Undefined -> 3'b100 both times.
